// File: rtl/jellyvl_etherneco_packet_scheduler.sv
// Packet scheduler for the etherneco ring: grants one requester at a time and
// tracks the packet until it returns, times out, and then enforces an idle gap.
module jellyvl_etherneco_packet_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned GAP_CYCLES    = 12,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned TIMEOUT       = 20000
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic                    enable,

    input  logic [NUM_REQ-1:0]      s_req_valid,
    input  logic [NUM_REQ*8-1:0]    s_req_type,
    input  logic [NUM_REQ*8-1:0]    s_req_node,
    input  logic [NUM_REQ*16-1:0]   s_req_length,
    output logic [NUM_REQ-1:0]      s_req_ready,

    output logic                    tx_start,
    output logic [7:0]              tx_type,
    output logic [7:0]              tx_node,
    output logic [15:0]             tx_length,
    output logic                    tx_cancel,
    input  logic                    tx_done,
    input  logic                    rx_done,

    output logic                    done_valid,
    output logic [2:0]              done_index,
    output logic                    done_timeout,
    output logic                    busy
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TX       = 2'd1;
    localparam logic [1:0] ST_WAIT_RET = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

    logic [1:0]               state,        state_next;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt,      tmo_cnt_next;
    logic [GAP_W-1:0]         gap_cnt,      gap_cnt_next;
    logic [IDX_W-1:0]         rr_ptr,       rr_ptr_next;
    logic [IDX_W-1:0]         cur_idx,      cur_idx_next;
    logic [NUM_REQ-1:0]       ready_next;
    logic                     tx_start_next, tx_cancel_next;
    logic [7:0]               tx_type_next, tx_node_next;
    logic [15:0]              tx_length_next;
    logic                     done_valid_next, done_timeout_next;
    logic [2:0]               done_index_next;
    logic                     busy_next;

    // Headers widened to the 8-requester maximum so index widths stay fixed
    logic [7:0]               valid_ext;
    logic [63:0]              type_ext;
    logic [63:0]              node_ext;
    logic [127:0]             length_ext;

    assign valid_ext  = 8'(s_req_valid);
    assign type_ext   = 64'(s_req_type);
    assign node_ext   = 64'(s_req_node);
    assign length_ext = 128'(s_req_length);

    logic                     grant_found;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         cand;
    logic [7:0]               grant_onehot;
    logic                     timeout_hit;
    logic [TIMEOUT_WIDTH-1:0] tmo_inc;

    // Requester 0 strict priority; 1..NUM_REQ-1 round-robin after rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (valid_ext[0]) begin
            grant_found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
                cand = IDX_W'((32'(rr_ptr) + k) % (NUM_REQ - 1) + 32'd1);
                if (!grant_found && valid_ext[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign grant_onehot = 8'd1 << grant_idx;
    assign timeout_hit  = (tmo_cnt >= TIMEOUT_WIDTH'(TIMEOUT - 1));
    assign tmo_inc      = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TIMEOUT_WIDTH'(1);

    always_comb begin
        state_next        = state;
        tmo_cnt_next      = tmo_cnt;
        gap_cnt_next      = gap_cnt;
        rr_ptr_next       = rr_ptr;
        cur_idx_next      = cur_idx;
        ready_next        = '0;
        tx_start_next     = 1'b0;
        tx_cancel_next    = 1'b0;
        tx_type_next      = tx_type;
        tx_node_next      = tx_node;
        tx_length_next    = tx_length;
        done_valid_next   = 1'b0;
        done_timeout_next = 1'b0;
        done_index_next   = done_index;

        case (state)
            ST_IDLE: begin
                if (enable && grant_found) begin
                    ready_next     = grant_onehot[NUM_REQ-1:0];
                    tx_start_next  = 1'b1;
                    tx_type_next   = type_ext[{grant_idx, 3'b000} +: 8];
                    tx_node_next   = node_ext[{grant_idx, 3'b000} +: 8];
                    tx_length_next = length_ext[{grant_idx, 4'b0000} +: 16];
                    cur_idx_next   = grant_idx;
                    tmo_cnt_next   = '0;
                    state_next     = ST_TX;
                    if (grant_idx != '0) begin
                        rr_ptr_next = grant_idx;
                    end
                end
            end
            ST_TX, ST_WAIT_RET: begin
                tmo_cnt_next = tmo_inc;
                // Returning packet beats a simultaneous timeout
                if (rx_done && (state == ST_WAIT_RET || tx_done)) begin
                    done_valid_next = 1'b1;
                    done_index_next = cur_idx;
                    gap_cnt_next    = '0;
                    state_next      = ST_GAP;
                end else if (timeout_hit) begin
                    tx_cancel_next    = 1'b1;
                    done_valid_next   = 1'b1;
                    done_timeout_next = 1'b1;
                    done_index_next   = cur_idx;
                    gap_cnt_next      = '0;
                    state_next        = ST_GAP;
                end else if (state == ST_TX && tx_done) begin
                    state_next = ST_WAIT_RET;
                end
            end
            default: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + GAP_W'(1);
                end
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            cur_idx      <= '0;
            s_req_ready  <= '0;
            tx_start     <= 1'b0;
            tx_cancel    <= 1'b0;
            tx_type      <= '0;
            tx_node      <= '0;
            tx_length    <= '0;
            done_valid   <= 1'b0;
            done_timeout <= 1'b0;
            done_index   <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            tmo_cnt      <= tmo_cnt_next;
            gap_cnt      <= gap_cnt_next;
            rr_ptr       <= rr_ptr_next;
            cur_idx      <= cur_idx_next;
            s_req_ready  <= ready_next;
            tx_start     <= tx_start_next;
            tx_cancel    <= tx_cancel_next;
            tx_type      <= tx_type_next;
            tx_node      <= tx_node_next;
            tx_length    <= tx_length_next;
            done_valid   <= done_valid_next;
            done_timeout <= done_timeout_next;
            done_index   <= done_index_next;
            busy         <= busy_next;
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_scheduler.sv
// Bench for the packet scheduler: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_jellyvl_etherneco_packet_scheduler;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 12;
    localparam int TW      = 16;
    localparam int TO      = 100;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b1;
    logic [NUM_REQ-1:0]    s_req_valid = '0;
    logic [NUM_REQ*8-1:0]  s_req_type = {8'h13, 8'h12, 8'h11, 8'h10};
    logic [NUM_REQ*8-1:0]  s_req_node = {8'h23, 8'h22, 8'h21, 8'h05};
    logic [NUM_REQ*16-1:0] s_req_length = {16'd48, 16'd32, 16'd20, 16'd12};
    logic [NUM_REQ-1:0]    s_req_ready;
    logic                  tx_start, tx_cancel;
    logic [7:0]            tx_type, tx_node;
    logic [15:0]           tx_length;
    logic                  tx_done = 1'b0;
    logic                  rx_done = 1'b0;
    logic                  done_valid, done_timeout, busy;
    logic [2:0]            done_index;

    jellyvl_etherneco_packet_scheduler #(
        .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP), .TIMEOUT_WIDTH(TW), .TIMEOUT(TO)
    ) dut (
        .reset(reset), .clk(clk), .enable(enable),
        .s_req_valid(s_req_valid), .s_req_type(s_req_type), .s_req_node(s_req_node),
        .s_req_length(s_req_length), .s_req_ready(s_req_ready),
        .tx_start(tx_start), .tx_type(tx_type), .tx_node(tx_node), .tx_length(tx_length),
        .tx_cancel(tx_cancel), .tx_done(tx_done), .rx_done(rx_done),
        .done_valid(done_valid), .done_index(done_index), .done_timeout(done_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding packet described by timestamps
    int           cyc = 0;
    int           cur = 0;
    bit           m_active = 0;
    bit           m_txed = 0;
    int           m_start = 0;
    int           m_idx = 0;
    int           m_idle_at = 0;
    int           m_rr = NUM_REQ - 1;
    logic [NUM_REQ-1:0] e_ready = '0;
    logic         e_start = 0, e_cancel = 0, e_dv = 0, e_dt = 0, e_busy = 0;
    logic [2:0]   e_di = '0;
    logic [7:0]   e_type = '0, e_node = '0;
    logic [15:0]  e_len = '0;

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
        int c;
        if (v[0]) return 0;
        for (int k = 1; k < NUM_REQ; k++) begin
            c = rr + k;
            if (c > NUM_REQ - 1) c = c - (NUM_REQ - 1);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0; m_txed = 0; m_idle_at = 0; m_rr = NUM_REQ - 1;
            e_ready = '0; e_start = 0; e_cancel = 0; e_dv = 0; e_dt = 0; e_busy = 0;
            e_di = '0; e_type = '0; e_node = '0; e_len = '0;
        end else begin
            int w, age;
            cur = cyc;
            cyc = cyc + 1;
            e_ready = '0; e_start = 0; e_cancel = 0; e_dv = 0; e_dt = 0;
            if (m_active) begin
                age = cur - m_start;
                if (rx_done && (m_txed || tx_done)) begin
                    e_dv = 1; e_di = 3'(m_idx); m_active = 0;
                    m_idle_at = cur + 1 + GAP;
                end else if (age >= TO - 1) begin
                    e_dv = 1; e_dt = 1; e_cancel = 1; e_di = 3'(m_idx); m_active = 0;
                    m_idle_at = cur + 1 + GAP;
                end else if (tx_done) begin
                    m_txed = 1;
                end
            end else if (cur >= m_idle_at && enable && s_req_valid != '0) begin
                w = pick(s_req_valid, m_rr);
                m_active = 1; m_txed = 0; m_start = cur + 1; m_idx = w;
                if (w != 0) m_rr = w;
                e_ready = NUM_REQ'(1) << w;
                e_start = 1;
                e_type = s_req_type[w*8 +: 8];
                e_node = s_req_node[w*8 +: 8];
                e_len  = s_req_length[w*16 +: 16];
            end
            e_busy = m_active || (cur + 1 < m_idle_at);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("ready", 32'(s_req_ready), 32'(e_ready));
            chk("tx_start", 32'(tx_start), 32'(e_start));
            chk("tx_cancel", 32'(tx_cancel), 32'(e_cancel));
            chk("done_valid", 32'(done_valid), 32'(e_dv));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("tx_hdr", {tx_type, tx_node, tx_length}, {e_type, e_node, e_len});
            if (e_dv) begin
                chk("done_index", 32'(done_index), 32'(e_di));
                chk("done_timeout", 32'(done_timeout), 32'(e_dt));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int g);
        g = -1;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (tx_start) break;
        end
        chk("grant_seen", 32'(tx_start), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) if (s_req_ready[i]) g = i;
    endtask

    task automatic do_packet(input int exp_idx, input string nm);
        int g;
        wait_start(g);
        chk(nm, 32'(g), 32'(exp_idx));
        step(2); tx_done = 1;
        step(1); tx_done = 0;
        step(2); rx_done = 1;
        step(1); rx_done = 0;
        chk("pkt_done", {29'd0, done_valid, done_index}, {29'd0, 1'b1, 3'(exp_idx)});
    endtask

    initial begin
        int g, n;
        step(3);
        chk("rst_outputs", {28'd0, s_req_ready}, 32'd0);
        chk("rst_busy", {30'd0, busy, tx_start}, 32'd0);
        reset = 0;
        step(2);

        // Single request on requester 0
        s_req_valid = 4'b0001;
        wait_start(g);
        s_req_valid = '0;
        chk("single_ready", 32'(s_req_ready), 32'h1);
        chk("single_type", 32'(tx_type), 32'h10);
        chk("single_len", 32'(tx_length), 32'd12);
        step(2); tx_done = 1;
        step(1); tx_done = 0;
        step(3); rx_done = 1;
        step(1); rx_done = 0;
        chk("single_done", {29'd0, done_valid, done_timeout, busy}, 32'b101);
        chk("single_idx", 32'(done_index), 32'd0);
        step(11);
        chk("gap_busy_hi", 32'(busy), 32'd1);
        step(1);
        chk("gap_busy_lo", 32'(busy), 32'd0);

        // Contention: requester 0 dominates, then 1,2,3 rotate
        s_req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) do_packet(0, "order_prio");
        s_req_valid = 4'b1110;
        do_packet(1, "order_rr0");
        do_packet(2, "order_rr1");
        do_packet(3, "order_rr2");
        do_packet(1, "order_rr3");
        do_packet(2, "order_rr4");
        s_req_valid = '0;

        // Timeout with no return packet
        s_req_valid = 4'b0100;
        wait_start(g);
        s_req_valid = '0;
        chk("to_grant", 32'(g), 32'd2);
        step(2); tx_done = 1;
        step(1); tx_done = 0;
        n = 3;
        for (int i = 0; i < 150; i++) begin
            step(1); n++;
            if (tx_cancel) break;
        end
        chk("to_latency", 32'(n), 32'd100);
        chk("to_done", {29'd0, done_valid, done_timeout, tx_cancel}, 32'b111);
        chk("to_idx", 32'(done_index), 32'd2);

        // rx_done lands on the timeout cycle
        s_req_valid = 4'b0010;
        wait_start(g);
        s_req_valid = '0;
        step(2); tx_done = 1;
        step(1); tx_done = 0;
        step(96); rx_done = 1;
        step(1); rx_done = 0;
        chk("race_done", {29'd0, done_valid, done_timeout, tx_cancel}, 32'b100);

        // Reset while waiting for the return packet
        s_req_valid = 4'b0010;
        wait_start(g);
        s_req_valid = '0;
        step(1); tx_done = 1;
        step(1); tx_done = 0;
        step(3);
        reset = 1;
        #1;
        chk("arst_ctl", {26'd0, s_req_ready, tx_start, tx_cancel},  32'd0);
        chk("arst_done", {26'd0, done_valid, done_index, done_timeout, busy}, 32'd0);
        chk("arst_hdr", {tx_type, tx_node, tx_length}, 32'd0);
        step(2);
        reset = 0;
        step(1); rx_done = 1;
        step(1); rx_done = 0;
        chk("late_rx", {30'd0, done_valid, busy}, 32'd0);
        step(2);

        // enable low during WAIT_RET holds off the pending grant
        s_req_valid = 4'b1000;
        wait_start(g);
        chk("en_grant", 32'(g), 32'd3);
        s_req_valid = 4'b0010;
        step(1); tx_done = 1;
        step(1); tx_done = 0; enable = 0;
        step(2); rx_done = 1;
        step(1); rx_done = 0;
        chk("en_done", 32'(done_valid), 32'd1);
        step(30);
        chk("en_blocked", {30'd0, tx_start, busy}, 32'd0);
        enable = 1;
        step(1);
        chk("en_resume", {27'd0, tx_start, s_req_ready}, {27'd0, 1'b1, 4'b0010});
        s_req_valid = '0;
        step(1); tx_done = 1;
        step(1); tx_done = 0;
        step(1); rx_done = 1;
        step(1); rx_done = 0;
        step(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
